// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial arithmetic datapaths: control states,
// default operand width and the bit-counter sizing helper.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // The counter must be able to represent WIDTH itself.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   localparam int CNT_WIDTH = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, bout set when that underflows.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per enabled SHIFT cycle; the result is
// a (WIDTH+1)-bit two's-complement difference whose MSB is the final borrow.
module serial_subtractor
   import serial_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             go,
   input  logic             enable,
   output logic [WIDTH:0]   diff,
   output logic             borrow,
   output logic             busy,
   output logic             done
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state, state_next;
   logic [WIDTH-1:0] ra, rb, result, result_next;
   logic [CW-1:0]    cnt;
   logic             bw, d, bw_next, last_bit;

   full_subtractor u_cell (
      .a    (ra[0]),
      .b    (rb[0]),
      .bin  (bw),
      .d    (d),
      .bout (bw_next)
   );

   assign result_next = {d, result[WIDTH-1:1]};
   assign last_bit    = (state == SHIFT) && enable && (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (go) state_next = LOAD;
         LOAD:    state_next = SHIFT;
         SHIFT:   if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The final bit's difference and borrow go straight into diff, so the
   // result is visible in the same cycle that done is asserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ra     <= '0;
         rb     <= '0;
         result <= '0;
         cnt    <= '0;
         bw     <= 1'b0;
         diff   <= '0;
      end else begin
         case (state)
            LOAD: begin
               ra     <= A;
               rb     <= B;
               result <= '0;
               cnt    <= '0;
               bw     <= 1'b0;
            end
            SHIFT: begin
               if (enable) begin
                  ra     <= ra >> 1;
                  rb     <= rb >> 1;
                  result <= result_next;
                  bw     <= bw_next;
                  cnt    <= cnt + 1'b1;
                  if (last_bit) diff <= {bw_next, result_next};
               end
            end
            default: ;
         endcase
      end
   end

   assign borrow = diff[WIDTH];
   assign busy   = (state == LOAD) || (state == SHIFT);
   assign done   = (state == DONE);

endmodule
